// File: rtl/tc0110pcr_palette.sv
// Palette stage behind TC0100SCN: 4096x16 dual-port palette RAM, 68000 address/data
// register pair with DTACK handshake, and a 2-tick pixel pipeline with sync/blank delay.
module tc0110pcr_palette #(
  parameter int AUTO_INC = 0,
  parameter int SS_IDX   = -1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ce_13m,
  input  logic        ce_pixel,
  input  logic        VA,
  input  logic [15:0] Din,
  output logic [15:0] Dout,
  input  logic        LDSn,
  input  logic        UDSn,
  input  logic        PCRCSn,
  input  logic        RW,
  output logic        DACKn,
  input  logic [11:0] SC,
  input  logic        HSYNn_in,
  input  logic        HBLOn_in,
  input  logic        VSYNn_in,
  input  logic        VBLOn_in,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic        HSYNn,
  output logic        HBLOn,
  output logic        VSYNn,
  output logic        VBLOn
);

  typedef enum logic [1:0] {IDLE, ACCESS, FETCH, HOLD} state_t;

  genvar gi;

  // Save-state hookup is reserved for a later revision.
  if (SS_IDX >= 0) begin : g_ss_reserved
  end

  state_t      state_reg, state_next;
  logic        cs_prev_reg;
  logic        dtack_n_reg, dtack_n_next;
  logic [15:0] dout_reg, dout_next;
  logic [11:0] pal_addr_reg, pal_addr_next;
  logic [1:0]  ram_we;
  logic        ram_rd;
  logic [15:0] cpu_q_reg;

  logic [15:0] pal_ram [0:4095];

  // ---------------- CPU side ----------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      cs_prev_reg  <= 1'b1;
      dtack_n_reg  <= 1'b1;
      dout_reg     <= '0;
      pal_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      dtack_n_reg  <= dtack_n_next;
      dout_reg     <= dout_next;
      pal_addr_reg <= pal_addr_next;
      if (ce_13m) cs_prev_reg <= PCRCSn;
    end
  end

  always_comb begin
    state_next    = state_reg;
    dtack_n_next  = dtack_n_reg;
    dout_next     = dout_reg;
    pal_addr_next = pal_addr_reg;
    ram_we        = 2'b00;
    ram_rd        = 1'b0;
    if (ce_13m) begin
      case (state_reg)
        IDLE: begin
          if (cs_prev_reg && !PCRCSn) state_next = ACCESS;
        end
        ACCESS: begin
          if (!VA) begin
            if (RW) dout_next = {3'b000, pal_addr_reg, 1'b0};
            else if (!LDSn) pal_addr_next = Din[12:1];
            dtack_n_next = 1'b0;
            state_next   = HOLD;
          end else begin
            if (AUTO_INC != 0) pal_addr_next = pal_addr_reg + 12'd1;
            if (RW) begin
              ram_rd     = 1'b1;
              state_next = FETCH;
            end else begin
              ram_we       = {~UDSn, ~LDSn};
              dtack_n_next = 1'b0;
              state_next   = HOLD;
            end
          end
        end
        FETCH: begin
          dout_next    = cpu_q_reg;
          dtack_n_next = 1'b0;
          state_next   = HOLD;
        end
        HOLD: begin
          if (PCRCSn) begin
            dtack_n_next = 1'b1;
            state_next   = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign Dout  = dout_reg;
  assign DACKn = PCRCSn ? 1'b0 : dtack_n_reg;

  // Port B: CPU. Writes are suppressed while reset is held so an aborted access never lands.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (resetn && ram_we[b]) pal_ram[pal_addr_reg][b*8 +: 8] <= Din[b*8 +: 8];
    end
    if (ram_rd) cpu_q_reg <= pal_ram[pal_addr_reg];
  end

  // ---------------- Pixel side ----------------
  logic [11:0] pix_addr_reg;
  logic [14:0] pix_q_reg;
  logic [3:0]  s1_tim_reg, s2_tim_reg, out_tim_reg;   // {HSYNn, HBLOn, VSYNn, VBLOn}
  logic [7:0]  comp_exp [3];
  logic [7:0]  r_reg, g_reg, b_reg;
  logic        blank_n;

  // Port A: pixel read-only; read-before-write gives old data on a same-address collision.
  always_ff @(posedge clk) begin
    if (ce_pixel) pix_q_reg <= pal_ram[pix_addr_reg][14:0];
  end

  for (gi = 0; gi < 3; gi++) begin : g_expand
    assign comp_exp[gi] = {pix_q_reg[gi*5 +: 5], pix_q_reg[gi*5+2 +: 3]};
  end

  assign blank_n = s2_tim_reg[2] & s2_tim_reg[0];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pix_addr_reg <= '0;
      s1_tim_reg   <= 4'b1010;
      s2_tim_reg   <= 4'b1010;
      out_tim_reg  <= 4'b1010;
      r_reg        <= '0;
      g_reg        <= '0;
      b_reg        <= '0;
    end else if (ce_pixel) begin
      pix_addr_reg <= SC;
      s1_tim_reg   <= {HSYNn_in, HBLOn_in, VSYNn_in, VBLOn_in};
      s2_tim_reg   <= s1_tim_reg;
      out_tim_reg  <= s2_tim_reg;
      r_reg        <= blank_n ? comp_exp[0] : 8'h00;
      g_reg        <= blank_n ? comp_exp[1] : 8'h00;
      b_reg        <= blank_n ? comp_exp[2] : 8'h00;
    end
  end

  assign R     = r_reg;
  assign G     = g_reg;
  assign B     = b_reg;
  assign HSYNn = out_tim_reg[3];
  assign HBLOn = out_tim_reg[2];
  assign VSYNn = out_tim_reg[1];
  assign VBLOn = out_tim_reg[0];

endmodule

// File: tb/tb_tc0110pcr_palette.sv
// Directed bench for tc0110pcr_palette: one instance with AUTO_INC=0 (pixel path and
// plain register access) and one with AUTO_INC=1 (address increment and held chip select).
module tb_tc0110pcr_palette;

  typedef struct packed {
    logic [7:0] r, g, b;
    logic       hs, hb, vs, vb;
  } pix_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ce_13m = 1'b0;
  logic        ce_pixel = 1'b0;
  logic [3:0]  ce_cnt = 4'd0;
  logic        VA, RW, UDSn, LDSn, cs0, cs1;
  logic [15:0] Din;
  logic [11:0] SC;
  logic        hs_in, hb_in, vs_in, vb_in;

  logic [15:0] dout0, dout1;
  logic        dack0, dack1;
  logic [7:0]  r0, g0, b0, r1, g1, b1;
  logic        hs0, hb0, vs0, vb0, hs1, hb1, vs1, vb1;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_ram [0:4095];
  logic [11:0] m_addr0;
  pix_t        pix_q[$];
  logic [15:0] rd_q[$];

  tc0110pcr_palette #(.AUTO_INC(0)) dut0 (
    .clk(clk), .resetn(resetn), .ce_13m(ce_13m), .ce_pixel(ce_pixel),
    .VA(VA), .Din(Din), .Dout(dout0), .LDSn(LDSn), .UDSn(UDSn), .PCRCSn(cs0), .RW(RW),
    .DACKn(dack0), .SC(SC), .HSYNn_in(hs_in), .HBLOn_in(hb_in), .VSYNn_in(vs_in),
    .VBLOn_in(vb_in), .R(r0), .G(g0), .B(b0), .HSYNn(hs0), .HBLOn(hb0), .VSYNn(vs0),
    .VBLOn(vb0)
  );

  tc0110pcr_palette #(.AUTO_INC(1)) dut1 (
    .clk(clk), .resetn(resetn), .ce_13m(ce_13m), .ce_pixel(ce_pixel),
    .VA(VA), .Din(Din), .Dout(dout1), .LDSn(LDSn), .UDSn(UDSn), .PCRCSn(cs1), .RW(RW),
    .DACKn(dack1), .SC(SC), .HSYNn_in(hs_in), .HBLOn_in(hb_in), .VSYNn_in(vs_in),
    .VBLOn_in(vb_in), .R(r1), .G(g1), .B(b1), .HSYNn(hs1), .HBLOn(hb1), .VSYNn(vs1),
    .VBLOn(vb1)
  );

  always #5 clk = ~clk;

  // ce_13m every 2nd clk, ce_pixel every 4th (always coincident with ce_13m).
  always @(negedge clk) begin
    ce_cnt   = ce_cnt + 4'd1;
    ce_13m   = ce_cnt[0];
    ce_pixel = (ce_cnt[1:0] == 2'b11);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wait_ce13();
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      if (ce_13m) return;
    end
    $display("FAIL ce_13m wait timeout");
    $fatal(1);
  endtask

  task automatic wait_pix();
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      if (ce_pixel) return;
    end
    $display("FAIL ce_pixel wait timeout");
    $fatal(1);
  endtask

  function automatic logic [7:0] expand5(input int c5);
    return 8'(c5 * 8 + c5 / 4);
  endfunction

  function automatic pix_t model_pix(input logic [11:0] sc, input logic hs, hb, vs, vb);
    pix_t p;
    int   w;
    w = int'(model_ram[sc]);
    p.hs = hs; p.hb = hb; p.vs = vs; p.vb = vb;
    if (hb && vb) begin
      p.r = expand5(w % 32);
      p.g = expand5((w / 32) % 32);
      p.b = expand5((w / 1024) % 32);
    end else begin
      p.r = 8'h00; p.g = 8'h00; p.b = 8'h00;
    end
    return p;
  endfunction

  task automatic pix_step(input logic [11:0] sc, input logic hs, hb, vs, vb);
    pix_t exp, got;
    SC = sc; hs_in = hs; hb_in = hb; vs_in = vs; vb_in = vb;
    wait_pix();
    #1;
    pix_q.push_back(model_pix(sc, hs, hb, vs, vb));
    if (pix_q.size() == 3) begin
      exp = pix_q.pop_front();
      got = {r0, g0, b0, hs0, hb0, vs0, vb0};
      $display("pix sc_in=%h rgb=%h_%h_%h sync=%b%b%b%b", sc, r0, g0, b0, hs0, hb0, vs0, vb0);
      check("pixel", 32'(got), 32'(exp));
    end
  endtask

  task automatic cpu_access(input int which, input logic va, input logic rw,
                            input logic [15:0] din, input logic uds, input logic lds,
                            input int hold, input logic [15:0] exp_rd, input string tag);
    int   n;
    int   exp_lat;
    logic acked, held_ok;
    logic [15:0] got_rd;
    exp_lat = (va && rw) ? 2 : 1;
    if (rw) rd_q.push_back(exp_rd);
    if (which == 0 && !rw) begin
      if (!va && !lds) m_addr0 = din[12:1];
      if (va && !uds) model_ram[m_addr0][15:8] = din[15:8];
      if (va && !lds) model_ram[m_addr0][7:0] = din[7:0];
    end
    wait_ce13();
    #1;
    VA = va; RW = rw; Din = din; UDSn = uds; LDSn = lds;
    if (which != 0) cs1 = 1'b0; else cs0 = 1'b0;
    n = 0;
    acked = 1'b0;
    while (n < 12 && !acked) begin
      wait_ce13();
      #1;
      n++;
      acked = ((which != 0 ? dack1 : dack0) === 1'b0);
    end
    got_rd = (which != 0) ? dout1 : dout0;
    $display("cpu dut%0d %s va=%b rw=%b din=%h dout=%h lat=%0d", which, tag, va, rw, din, got_rd, n - 1);
    check({tag, " latency"}, 32'(n - 1), 32'(exp_lat));
    if (rw) check({tag, " data"}, 32'(got_rd), 32'(rd_q.pop_front()));
    held_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      wait_ce13();
      #1;
      if ((which != 0 ? dack1 : dack0) !== 1'b0) held_ok = 1'b0;
    end
    if (hold > 0) check({tag, " dtack held"}, 32'(held_ok), 32'(1));
    cs0 = 1'b1; cs1 = 1'b1;
    wait_ce13();
    wait_ce13();
    #1;
    RW = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; cs0 = 1'b1; cs1 = 1'b1; VA = 1'b0; RW = 1'b1; Din = '0;
    UDSn = 1'b1; LDSn = 1'b1; SC = '0; hs_in = 1'b1; hb_in = 1'b1; vs_in = 1'b1; vb_in = 1'b1;
    m_addr0 = '0;

    // Reset with random colour index
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      SC = 12'($urandom);
      @(posedge clk);
    end
    #1;
    $display("reset rgb=%h_%h_%h dack=%b dout=%h", r0, g0, b0, dack0, dout0);
    check("reset rgb", 32'({r0, g0, b0}), 32'(0));
    check("reset hblo", 32'(hb0), 32'(0));
    check("reset vblo", 32'(vb0), 32'(0));
    check("reset hsyn", 32'(hs0), 32'(1));
    check("reset vsyn", 32'(vs0), 32'(1));
    check("reset dack", 32'(dack0), 32'(0));
    check("reset dout0", 32'(dout0), 32'(0));
    check("reset dout1", 32'(dout1), 32'(0));
    resetn = 1'b1;

    // Palette write / read on the non-incrementing instance
    cpu_access(0, 1'b0, 1'b0, 16'h0020, 1'b1, 1'b0, 0, 16'h0, "wr addr 010");
    cpu_access(0, 1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b0, 0, 16'h0, "wr data 7fff");
    cpu_access(0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 0, 16'h7FFF, "rd data");
    cpu_access(0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 0, 16'h0020, "rd addr");
    cpu_access(0, 1'b0, 1'b0, 16'h000A, 1'b1, 1'b0, 0, 16'h0, "wr addr 005");
    cpu_access(0, 1'b1, 1'b0, 16'h001F, 1'b0, 1'b0, 0, 16'h0, "wr data 001f");
    cpu_access(0, 1'b0, 1'b0, 16'h0246, 1'b1, 1'b0, 0, 16'h0, "wr addr 123");
    cpu_access(0, 1'b1, 1'b0, 16'h56B5, 1'b0, 1'b0, 0, 16'h0, "wr data 56b5");

    // Pixel path with varying index to pin down latency
    pix_q.delete();
    pix_step(12'h010, 1, 1, 1, 1);
    pix_step(12'h005, 1, 1, 1, 1);
    pix_step(12'h123, 1, 1, 1, 1);
    pix_step(12'h010, 1, 1, 1, 1);
    pix_step(12'h123, 1, 1, 1, 1);
    pix_step(12'h005, 1, 1, 1, 1);
    pix_step(12'h010, 1, 1, 1, 1);
    pix_step(12'h010, 1, 1, 1, 1);

    // Upper byte only, then an address write without LDSn
    cpu_access(0, 1'b0, 1'b0, 16'h0020, 1'b1, 1'b0, 0, 16'h0, "wr addr 010");
    cpu_access(0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 0, 16'h0, "wr hi byte");
    cpu_access(0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 0, 16'h00FF, "rd byte data");
    cpu_access(0, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b1, 0, 16'h0, "wr addr no lds");
    cpu_access(0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 0, 16'h0020, "rd addr kept");
    pix_q.delete();
    for (int i = 0; i < 5; i++) pix_step(12'h010, 1, 1, 1, 1);

    // Blanking and sync delay
    pix_q.delete();
    for (int i = 0; i < 14; i++)
      pix_step(12'h005, !(i == 8 || i == 9), !(i >= 4 && i <= 6), i != 11, i != 11);

    // Auto-increment with wrap
    cpu_access(1, 1'b0, 1'b0, 16'h1FFE, 1'b1, 1'b0, 0, 16'h0, "ai wr addr fff");
    cpu_access(1, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 0, 16'h0, "ai wr 1234");
    cpu_access(1, 1'b1, 1'b0, 16'h5678, 1'b0, 1'b0, 0, 16'h0, "ai wr 5678");
    cpu_access(1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 0, 16'h0002, "ai rd addr");
    cpu_access(1, 1'b0, 1'b0, 16'h1FFE, 1'b1, 1'b0, 0, 16'h0, "ai wr addr fff");
    cpu_access(1, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 0, 16'h1234, "ai rd fff");
    cpu_access(1, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 0, 16'h5678, "ai rd 000");

    // Chip select held low for 10 ticks: one write, one increment
    cpu_access(1, 1'b0, 1'b0, 16'h0202, 1'b1, 1'b0, 0, 16'h0, "hold wr addr 101");
    cpu_access(1, 1'b1, 1'b0, 16'h1111, 1'b0, 1'b0, 0, 16'h0, "hold wr 1111");
    cpu_access(1, 1'b0, 1'b0, 16'h0200, 1'b1, 1'b0, 0, 16'h0, "hold wr addr 100");
    cpu_access(1, 1'b1, 1'b0, 16'hABCD, 1'b0, 1'b0, 10, 16'h0, "hold wr abcd");
    cpu_access(1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 0, 16'h0202, "hold rd addr");
    cpu_access(1, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 0, 16'h1111, "hold rd 101");
    cpu_access(1, 1'b0, 1'b0, 16'h0200, 1'b1, 1'b0, 0, 16'h0, "hold wr addr 100");
    cpu_access(1, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 0, 16'hABCD, "hold rd 100");

    // Reset landing on the ACCESS tick drops the pending write
    cpu_access(0, 1'b0, 1'b0, 16'h0020, 1'b1, 1'b0, 0, 16'h0, "abort wr addr");
    wait_ce13();
    #1;
    VA = 1'b1; RW = 1'b0; Din = 16'h1234; UDSn = 1'b0; LDSn = 1'b0; cs0 = 1'b0;
    wait_ce13();
    #1;
    resetn = 1'b0;
    wait_ce13();
    #1;
    cs0 = 1'b1; RW = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    $display("abort dout=%h", dout0);
    check("abort dout", 32'(dout0), 32'(0));
    cpu_access(0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 0, 16'h0000, "abort rd addr");
    cpu_access(0, 1'b0, 1'b0, 16'h0020, 1'b1, 1'b0, 0, 16'h0, "abort wr addr");
    cpu_access(0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 0, 16'h00FF, "abort rd data");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
